// File: rtl/wave_gen.sv
// wave_gen: triangle / saw-up / saw-down / square generator with a prescaled phase stepper.
// Defining WAVE_GEN_DUTY_EN adds the duty port; square then goes high while phase < duty.
module wave_gen #(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sync,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] invslope,
    input  logic [WIDTH-1:0]     peak,
`ifdef WAVE_GEN_DUTY_EN
    input  logic [WIDTH-1:0]     duty,
`endif
    output logic [WIDTH-1:0]     out,
    output logic                 dir,
    output logic                 cyc
);
    localparam logic [1:0]           MODE_TRI = 2'b00;
    localparam logic [1:0]           MODE_UP  = 2'b01;
    localparam logic [1:0]           MODE_DN  = 2'b10;
    localparam logic [WIDTH-1:0]     ONE      = WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0]     phase_q, phase_d, out_q, out_d;
    logic                 dir_q, dir_d, cyc_q, cyc_d, tick, sq_hi;

    always_comb begin
        tick    = en && (div_q == invslope);
        div_d   = div_q;
        phase_d = phase_q;
        dir_d   = dir_q;
        cyc_d   = 1'b0;
        if (en)
            div_d = tick ? '0 : div_q + DIV_ONE;
        if (tick) begin
            // A zero peak pins the phase and suppresses period pulses in every mode.
            if (peak == '0) begin
                phase_d = '0;
                dir_d   = 1'b1;
            end else if (mode == MODE_TRI) begin
                if (phase_q > peak) begin
                    phase_d = peak;
                    dir_d   = 1'b0;
                end else if (dir_q && phase_q == peak) begin
                    phase_d = peak - ONE;
                    dir_d   = 1'b0;
                end else if (!dir_q && phase_q == '0) begin
                    phase_d = ONE;
                    dir_d   = 1'b1;
                end else begin
                    phase_d = dir_q ? phase_q + ONE : phase_q - ONE;
                end
                cyc_d = (phase_q == ONE) && (phase_d == '0);
            end else begin
                dir_d   = 1'b1;
                phase_d = (phase_q >= peak) ? '0 : phase_q + ONE;
                cyc_d   = (phase_q == peak);
            end
        end
        if (sync) begin
            div_d   = '0;
            phase_d = '0;
            dir_d   = 1'b1;
            cyc_d   = 1'b0;
        end
`ifdef WAVE_GEN_DUTY_EN
        sq_hi = phase_q < duty;
`else
        sq_hi = phase_q <= (peak >> 1);
`endif
        out_d = (mode == MODE_TRI || mode == MODE_UP) ? phase_q :
                (mode == MODE_DN) ? peak - phase_q :
                sq_hi ? peak : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= '0;
            phase_q <= '0;
            dir_q   <= 1'b1;
            cyc_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
            dir_q   <= dir_d;
            cyc_q   <= cyc_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;
    assign dir = dir_q;
    assign cyc = cyc_q;
endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: directed checks of wave_gen sequences, freeze, sync, clamp and async reset.
module tb_wave_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       sync = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] invslope = 8'd0;
    logic [7:0] peak = 8'd0;
    logic [7:0] duty = 8'd2;
    logic [7:0] out;
    logic       dir, cyc;
    int         checks = 0;
    int         failures = 0;

    wave_gen #(.WIDTH(8), .DIV_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .mode(mode),
        .invslope(invslope), .peak(peak),
`ifdef WAVE_GEN_DUTY_EN
        .duty(duty),
`endif
        .out(out), .dir(dir), .cyc(cyc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int tri_out[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    int tri_cyc[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    int tri_dir[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    int dn_out[16] = '{4, 4, 4, 3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0, 4};
`ifdef WAVE_GEN_DUTY_EN
    int sq_out[9] = '{7, 7, 0, 0, 0, 0, 0, 0, 7};
`else
    int sq_out[9] = '{7, 7, 7, 7, 0, 0, 0, 0, 7};
`endif

    initial begin
        mode = 2'b00; peak = 8'd3; invslope = 8'd0; en = 1'b1;
        #12;
        check("rst_out", out, 0);
        check("rst_dir", dir, 1);
        check("rst_cyc", cyc, 0);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("tri_out%0d", i), out, tri_out[i]);
            check($sformatf("tri_cyc%0d", i), cyc, tri_cyc[i]);
            check($sformatf("tri_dir%0d", i), dir, tri_dir[i]);
        end

        mode = 2'b10; peak = 8'd4; invslope = 8'd2; sync = 1'b1;
        step();
        sync = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            check($sformatf("dn_out%0d", i), out, dn_out[i]);
            check($sformatf("dn_cyc%0d", i), cyc, (i == 14) ? 1 : 0);
        end

        mode = 2'b11; peak = 8'd7; invslope = 8'd0; sync = 1'b1;
        step();
        sync = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("sq_out%0d", i), out, sq_out[i]);
            check($sformatf("sq_cyc%0d", i), cyc, (i == 7) ? 1 : 0);
        end

        mode = 2'b00; peak = 8'd255; invslope = 8'd0; sync = 1'b1;
        step();
        sync = 1'b0;
        repeat (199) step();
        step();
        check("clamp_pre_out", out, 199);
        peak = 8'd100;
        step();
        check("clamp_dir", dir, 0);
        check("clamp_out200", out, 200);
        step();
        check("clamp_out100", out, 100);
        step();
        check("clamp_out99", out, 99);
        check("clamp_dir_dn", dir, 0);
        en = 1'b0; sync = 1'b1;
        step();
        check("sync_dir", dir, 1);
        check("sync_cyc", cyc, 0);
        sync = 1'b0;
        step();
        check("sync_out", out, 0);
        check("sync_cyc2", cyc, 0);

        en = 1'b1; mode = 2'b01; peak = 8'd50; invslope = 8'd3; sync = 1'b1;
        step();
        sync = 1'b0;
        repeat (10) step();
        check("frz_pre", out, 2);
        en = 1'b0;
        repeat (10) step();
        check("frz_out", out, 2);
        check("frz_dir", dir, 1);
        en = 1'b1;
        step();
        check("frz_e11", out, 2);
        step();
        check("frz_e12", out, 2);
        step();
        check("frz_e13", out, 3);

        mode = 2'b01; peak = 8'd0; invslope = 8'd0; sync = 1'b1;
        step();
        sync = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("p0_out%0d", i), out, 0);
            check($sformatf("p0_cyc%0d", i), cyc, 0);
        end

        peak = 8'd50; sync = 1'b1;
        step();
        sync = 1'b0;
        repeat (5) step();
        check("ar_pre", out, 4);
        #2 rst = 1'b0;
        #1;
        check("ar_out", out, 0);
        check("ar_dir", dir, 1);
        check("ar_cyc", cyc, 0);
        invslope = 8'd2;
        step();
        check("ar_hold", out, 0);
        #2 rst = 1'b1;
        step();
        step();
        step();
        check("ar_e3", out, 0);
        step();
        check("ar_e4", out, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
